// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Optional macro ALU_ARB_FIXED_PRIO_EN selects fixed priority in rr_arbiter2.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [2:0] CMD_ADD = 3'd0;
    localparam logic [2:0] CMD_SUB = 3'd1;
    localparam logic [2:0] CMD_XOR = 3'd2;
    localparam logic [2:0] CMD_SLT = 3'd3;

    // Anything above the last defined opcode is illegal.
    function automatic logic is_illegal(input logic [31:0] cmd);
        return cmd > 32'(CMD_SLT);
    endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// Two-input grant logic with a last-grant register.
// ALU_ARB_FIXED_PRIO_EN: requester 0 always wins contention.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic       grant
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    logic unused;
    assign unused = ^{clk, reset, update};
    assign grant  = ~req[0];
`else
    logic last_grant;

    // Contention goes to whoever did not win last time.
    assign grant = (req[0] & req[1]) ? ~last_grant : req[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (update) begin
            last_grant <= grant;
        end
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters.
// Optional macro ALU_ARB_FIXED_PRIO_EN: fixed priority instead of round-robin.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CMD_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [CMD_W-1:0] req0_cmd,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [CMD_W-1:0] req1_cmd,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [CMD_W-1:0] alu_cmd,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err,
    input  logic             rsp_ready
);

    state_t           state;
    state_t           next_state;
    logic             any;
    logic             grant;
    logic             accept;
    logic             sel_illegal;
    logic             err_q;
    logic             id_q;
    logic [CMD_W-1:0] sel_cmd;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    assign any = req0_valid | req1_valid;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    ({req1_valid, req0_valid}),
        .update (accept),
        .grant  (grant)
    );

    always_comb begin
        sel_cmd = grant ? req1_cmd : req0_cmd;
        sel_a   = grant ? req1_a   : req0_a;
        sel_b   = grant ? req1_b   : req0_b;
    end

    assign sel_illegal = is_illegal(32'(sel_cmd));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        unique case (state)
            IDLE: begin
                if (any) begin
                    accept     = 1'b1;
                    req0_ready = ~grant;
                    req1_ready = grant;
                    next_state = ISSUE;
                end
            end
            ISSUE: next_state = HOLD;
            HOLD: begin
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // alu_* double as the latched request; they only move on acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_cmd    <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            err_q      <= 1'b0;
            id_q       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            if (accept) begin
                alu_cmd <= sel_illegal ? '0 : sel_cmd;
                alu_a   <= sel_a;
                alu_b   <= sel_b;
                err_q   <= sel_illegal;
                id_q    <= grant;
            end
            if (state == ISSUE) begin
                rsp_valid  <= 1'b1;
                rsp_id     <= id_q;
                rsp_err    <= err_q;
                rsp_result <= err_q ? '0 : alu_result;
                rsp_zero   <= err_q | alu_zero;
            end else if (state == HOLD && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural ALU.
// Expected grant order follows ALU_ARB_FIXED_PRIO_EN when defined.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid;
    logic        req0_ready;
    logic [2:0]  req0_cmd;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [2:0]  req1_cmd;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [2:0]  alu_cmd;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        rsp_valid;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_err;
    logic        rsp_ready;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_cmd   (req0_cmd),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_cmd   (req1_cmd),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .alu_cmd    (alu_cmd),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .rsp_ready  (rsp_ready)
    );

    // External ALU the arbiter drives.
    always_comb begin
        alu_result = 32'd0;
        case (alu_cmd)
            3'd0: alu_result = alu_a + alu_b;
            3'd1: alu_result = alu_a - alu_b;
            3'd2: alu_result = alu_a ^ alu_b;
            3'd3: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: alu_result = 32'hDEAD_BEEF;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic test_reset();
        reset = 1'b1;
        req0_valid = 0; req0_cmd = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_cmd = 0; req1_a = 0; req1_b = 0;
        rsp_ready = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_id, rsp_zero, rsp_err} !== 4'b0 || rsp_result !== 32'd0)
            $display("FAIL reset_rsp: valid=%b id=%b res=%h z=%b err=%b want all 0",
                     rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err);
        else passes++;
        checks++;
        if (alu_cmd !== 3'd0 || alu_a !== 32'd0 || alu_b !== 32'd0 ||
            req0_ready !== 1'b0 || req1_ready !== 1'b0)
            $display("FAIL reset_alu: cmd=%0d a=%h b=%h rdy=%b%b want 0",
                     alu_cmd, alu_a, alu_b, req0_ready, req1_ready);
        else passes++;
    endtask

    task automatic test_add();
        @(posedge clk);
        #1 req0_valid = 1; req0_cmd = 3'd0; req0_a = 32'd5; req0_b = 32'd7;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
            $display("FAIL add_ready: got %b%b want req0=1 req1=0", req0_ready, req1_ready);
        else passes++;
        @(posedge clk);
        #1 req0_valid = 0;
        @(negedge clk);
        checks++;
        if (alu_cmd !== 3'd0 || alu_a !== 32'd5 || alu_b !== 32'd7 ||
            rsp_valid !== 1'b0 || req0_ready !== 1'b0)
            $display("FAIL add_issue: cmd=%0d a=%0d b=%0d rv=%b rdy=%b want 0/5/7/0/0",
                     alu_cmd, alu_a, alu_b, rsp_valid, req0_ready);
        else passes++;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 32'd12 || rsp_zero !== 1'b0 ||
            rsp_id !== 1'b0 || rsp_err !== 1'b0)
            $display("FAIL add_rsp: v=%b res=%0d z=%b id=%b err=%b want 1/12/0/0/0",
                     rsp_valid, rsp_result, rsp_zero, rsp_id, rsp_err);
        else passes++;
        rsp_ready = 1;
        @(posedge clk);
        #1 rsp_ready = 0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0)
            $display("FAIL add_release: rsp_valid=%b want 0", rsp_valid);
        else passes++;
    endtask

    task automatic test_sub();
        @(posedge clk);
        #1 req1_valid = 1; req1_cmd = 3'd1; req1_a = 32'd9; req1_b = 32'd9;
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0)
            $display("FAIL sub_ready: got %b%b want req0=0 req1=1", req0_ready, req1_ready);
        else passes++;
        @(posedge clk);
        #1 req1_valid = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 32'd0 || rsp_zero !== 1'b1 || rsp_id !== 1'b1)
            $display("FAIL sub_rsp: v=%b res=%0d z=%b id=%b want 1/0/1/1",
                     rsp_valid, rsp_result, rsp_zero, rsp_id);
        else passes++;
        rsp_ready = 1;
        @(posedge clk);
        #1 rsp_ready = 0;
    endtask

    task automatic test_round_robin();
        int got[4];
        int exp_g[4];
        int n = 0;
        int last_cyc = 0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_g = '{0, 0, 0, 0};
`else
        exp_g = '{0, 1, 0, 1};
`endif
        @(posedge clk);
        #1;
        rsp_ready = 1;
        req0_valid = 1; req0_cmd = 3'd0; req0_a = 32'd1; req0_b = 32'd2;
        req1_valid = 1; req1_cmd = 3'd2; req1_a = 32'hF0; req1_b = 32'hFF;
        for (int cyc = 0; cyc < 60 && n < 4; cyc++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                if (n > 0) begin
                    checks++;
                    if (cyc - last_cyc !== 3)
                        $display("FAIL rr_spacing: gap=%0d want 3", cyc - last_cyc);
                    else passes++;
                end
                got[n] = req1_ready ? 1 : 0;
                last_cyc = cyc;
                n++;
            end
        end
        checks++;
        if (n !== 4)
            $display("FAIL rr_timeout: grants=%0d want 4", n);
        else passes++;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got[i] !== exp_g[i])
                $display("FAIL rr_grant%0d: got %0d want %0d", i, got[i], exp_g[i]);
            else passes++;
        end
        @(posedge clk);
        #1 req0_valid = 0; req1_valid = 0;
        repeat (3) @(posedge clk);
        #1 rsp_ready = 0;
    endtask

    task automatic test_hold_stall();
        @(posedge clk);
        #1 req0_valid = 1; req0_cmd = 3'd0; req0_a = 32'h7FFF_FFFF; req0_b = 32'd1;
        @(posedge clk);
        #1 req0_valid = 0;
        req1_valid = 1; req1_cmd = 3'd3; req1_a = 32'hFFFF_FFFF; req1_b = 32'd1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_result !== 32'h8000_0000 || rsp_id !== 1'b0 ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0)
                $display("FAIL hold_%0d: v=%b res=%h id=%b rdy=%b%b want 1/80000000/0/00",
                         i, rsp_valid, rsp_result, rsp_id, req0_ready, req1_ready);
            else passes++;
        end
        rsp_ready = 1;
        @(posedge clk);
        #1 rsp_ready = 0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req1_ready !== 1'b1)
            $display("FAIL hold_release: v=%b req1_ready=%b want 0/1", rsp_valid, req1_ready);
        else passes++;
        @(posedge clk);
        #1 req1_valid = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 32'd1 || rsp_id !== 1'b1)
            $display("FAIL slt_rsp: v=%b res=%0d id=%b want 1/1/1", rsp_valid, rsp_result, rsp_id);
        else passes++;
        rsp_ready = 1;
        @(posedge clk);
        #1 rsp_ready = 0;
    endtask

    task automatic test_illegal();
        @(posedge clk);
        #1 req0_valid = 1; req0_cmd = 3'd6; req0_a = 32'd3; req0_b = 32'd4;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1)
            $display("FAIL ill_ready: req0_ready=%b want 1", req0_ready);
        else passes++;
        @(posedge clk);
        #1 req0_valid = 0;
        @(negedge clk);
        checks++;
        if (alu_cmd !== 3'd0 || alu_a !== 32'd3 || alu_b !== 32'd4)
            $display("FAIL ill_issue: cmd=%0d a=%0d b=%0d want 0/3/4", alu_cmd, alu_a, alu_b);
        else passes++;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_result !== 32'd0 || rsp_zero !== 1'b1)
            $display("FAIL ill_rsp: v=%b err=%b res=%0d z=%b want 1/1/0/1",
                     rsp_valid, rsp_err, rsp_result, rsp_zero);
        else passes++;
        rsp_ready = 1;
        @(posedge clk);
        #1 rsp_ready = 0;
    endtask

    task automatic test_reset_mid();
        @(posedge clk);
        #1 req1_valid = 1; req1_cmd = 3'd0; req1_a = 32'd2; req1_b = 32'd2;
        @(posedge clk);
        #1 req1_valid = 0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_result !== 32'd0 || rsp_err !== 1'b0 ||
            alu_cmd !== 3'd0 || alu_a !== 32'd0 || alu_b !== 32'd0 ||
            req0_ready !== 1'b0 || req1_ready !== 1'b0)
            $display("FAIL rst_mid: v=%b res=%h a=%h b=%h rdy=%b%b want all 0",
                     rsp_valid, rsp_result, alu_a, alu_b, req0_ready, req1_ready);
        else passes++;
        repeat (3) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0)
            $display("FAIL rst_drop: rsp_valid=%b want 0", rsp_valid);
        else passes++;
        req0_valid = 1; req0_cmd = 3'd0; req0_a = 32'd1; req0_b = 32'd1;
        req1_valid = 1; req1_cmd = 3'd0; req1_a = 32'd1; req1_b = 32'd1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
            $display("FAIL rst_first: got %b%b want req0=1 req1=0", req0_ready, req1_ready);
        else passes++;
        @(posedge clk);
        #1 req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        repeat (3) @(posedge clk);
        #1 rsp_ready = 0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_round_robin();
        test_hold_stall();
        test_illegal();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
